// File: rtl/seq_control_unit_pkg.sv
// Shared constants, control-bundle type and decode helpers for seq_control_unit.
// Optional feature: CU_BASE_WRITEBACK_EN adds the base-register writeback state.
package seq_control_unit_pkg;

  localparam int unsigned NUM_REGS            = 16;
  localparam int unsigned REG_ADDR_LEN        = $clog2(NUM_REGS);
  localparam int unsigned EXECUTE_COMMAND_LEN = 4;
  localparam int unsigned OFFSET_LEN          = REG_ADDR_LEN + 3;
  localparam int unsigned COUNT_LEN           = REG_ADDR_LEN + 1;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_BLOCK  = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MOV = 4'b0001;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ADD = 4'b0010;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ADC = 4'b0011;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_SUB = 4'b0100;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_SBC = 4'b0101;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_AND = 4'b0110;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ORR = 4'b0111;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_EOR = 4'b1000;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MVN = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEQ  = 2'b01
`ifdef CU_BASE_WRITEBACK_EN
    , S_WB = 2'b10
`endif
  } state_e;

  typedef struct packed {
    logic                           valid;
    logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd;
    logic                           mem_read;
    logic                           mem_write;
    logic                           wb_enable;
    logic                           immediate;
    logic                           branch_taken;
    logic                           status_write_enable;
    logic                           ignore_hazard;
    logic [REG_ADDR_LEN-1:0]        dest_reg;
    logic [OFFSET_LEN-1:0]          addr_offset;
  } ctrl_t;

  // Decode of a single-cycle (arith/mem/branch) instruction.
  function automatic ctrl_t decode_single(input logic [1:0] mode, input logic [3:0] opcode,
                                          input logic s, input logic imm);
    ctrl_t c;
    c       = '0;
    c.valid = 1'b1;
    case (mode)
      MODE_ARITH: begin
        c.immediate           = imm;
        c.wb_enable           = 1'b1;
        c.status_write_enable = s;
        case (opcode)
          OP_AND: c.exe_cmd = EXE_AND;
          OP_EOR: c.exe_cmd = EXE_EOR;
          OP_SUB: c.exe_cmd = EXE_SUB;
          OP_ADD: c.exe_cmd = EXE_ADD;
          OP_ADC: c.exe_cmd = EXE_ADC;
          OP_SBC: c.exe_cmd = EXE_SBC;
          OP_ORR: c.exe_cmd = EXE_ORR;
          OP_MOV: begin c.exe_cmd = EXE_MOV; c.ignore_hazard = 1'b1; end
          OP_MVN: begin c.exe_cmd = EXE_MVN; c.ignore_hazard = 1'b1; end
          OP_CMP: begin c.exe_cmd = EXE_SUB; c.wb_enable = 1'b0; end
          OP_TST: begin c.exe_cmd = EXE_AND; c.wb_enable = 1'b0; end
          default: begin
            c.wb_enable           = 1'b0;
            c.status_write_enable = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        c.exe_cmd   = EXE_ADD;
        c.immediate = imm;
        c.mem_read  = s;
        c.wb_enable = s;
        c.mem_write = ~s;
      end
      MODE_BRANCH: begin
        c.branch_taken  = 1'b1;
        c.ignore_hazard = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // One load/store micro-op of a block transfer.
  function automatic ctrl_t block_op(input logic load, input logic [REG_ADDR_LEN-1:0] idx,
                                     input logic [OFFSET_LEN-1:0] offset);
    ctrl_t c;
    c             = '0;
    c.valid       = 1'b1;
    c.exe_cmd     = EXE_ADD;
    c.immediate   = 1'b1;
    c.mem_read    = load;
    c.wb_enable   = load;
    c.mem_write   = ~load;
    c.dest_reg    = idx;
    c.addr_offset = offset;
    return c;
  endfunction

  // Base-register update issued after the last transfer.
  function automatic ctrl_t wb_op(input logic [REG_ADDR_LEN-1:0] rn,
                                  input logic [OFFSET_LEN-1:0] offset);
    ctrl_t c;
    c             = '0;
    c.valid       = 1'b1;
    c.exe_cmd     = EXE_ADD;
    c.immediate   = 1'b1;
    c.wb_enable   = 1'b1;
    c.dest_reg    = rn;
    c.addr_offset = offset;
    return c;
  endfunction

endpackage

// File: rtl/seq_control_unit_if.sv
// IF/ID-side instruction fields in, ID/EXE control bundle out.
interface seq_control_unit_if;
  import seq_control_unit_pkg::*;

  logic                           valid_in;
  logic                           stall;
  logic                           flush;
  logic [1:0]                     mode;
  logic [3:0]                     opcode;
  logic                           s;
  logic                           immediate_in;
  logic [REG_ADDR_LEN-1:0]        rn;
  logic [NUM_REGS-1:0]            reg_list;

  logic                           valid_out;
  logic [EXECUTE_COMMAND_LEN-1:0] execute_command;
  logic                           mem_read;
  logic                           mem_write;
  logic                           wb_enable;
  logic                           immediate;
  logic                           branch_taken;
  logic                           status_write_enable;
  logic                           ignore_hazard;
  logic [REG_ADDR_LEN-1:0]        dest_reg;
  logic [OFFSET_LEN-1:0]          addr_offset;
  logic                           busy;

  modport master (
    output valid_in, stall, flush, mode, opcode, s, immediate_in, rn, reg_list,
    input  valid_out, execute_command, mem_read, mem_write, wb_enable, immediate,
           branch_taken, status_write_enable, ignore_hazard, dest_reg, addr_offset, busy
  );

  modport slave (
    input  valid_in, stall, flush, mode, opcode, s, immediate_in, rn, reg_list,
    output valid_out, execute_command, mem_read, mem_write, wb_enable, immediate,
           branch_taken, status_write_enable, ignore_hazard, dest_reg, addr_offset, busy
  );
endinterface

// File: rtl/seq_control_unit_lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit and whether any bit is set.
module lowest_set_bit #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [NUM_REGS-1:0]         i_vec,
  output logic                        o_found_c,
  output logic [$clog2(NUM_REGS)-1:0] o_index_c
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    o_found_c = 1'b0;
    o_index_c = '0;
    for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found_c = 1'b1;
        o_index_c = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/seq_control_unit.sv
// Registered ID-stage control unit with LDM/STM micro-op sequencing, stall and flush.
// Optional feature: CU_BASE_WRITEBACK_EN appends a base-register writeback micro-op.
module seq_control_unit
  import seq_control_unit_pkg::*;
(
  input logic               clk,
  input logic               rst,
  seq_control_unit_if.slave bus
);

  state_e                  r_state, w_next_state;
  logic [NUM_REGS-1:0]     r_mask, w_next_mask;
  logic [COUNT_LEN-1:0]    r_count, w_next_count;
  logic                    r_load, w_next_load;
  logic [REG_ADDR_LEN-1:0] r_rn, w_next_rn;
  ctrl_t                   r_ctrl, w_next_ctrl;
  logic                    r_busy, w_next_busy;

  logic [NUM_REGS-1:0]     w_scan;
  logic [NUM_REGS-1:0]     w_mask_rest;
  logic                    w_found;
  logic [REG_ADDR_LEN-1:0] w_idx;
  logic [OFFSET_LEN-1:0]   w_offset;

  // In IDLE the new list is scanned directly so the first micro-op issues on accept.
  assign w_scan      = (r_state == S_SEQ) ? r_mask : bus.reg_list;
  assign w_mask_rest = w_scan & ~(NUM_REGS'(1) << w_idx);
  assign w_offset    = OFFSET_LEN'({r_count, 2'b00});

  lowest_set_bit #(.NUM_REGS(NUM_REGS)) u_lsb (
    .i_vec     (w_scan),
    .o_found_c (w_found),
    .o_index_c (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_count <= '0;
      r_load  <= 1'b0;
      r_rn    <= '0;
      r_ctrl  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_mask  <= w_next_mask;
      r_count <= w_next_count;
      r_load  <= w_next_load;
      r_rn    <= w_next_rn;
      r_ctrl  <= w_next_ctrl;
      r_busy  <= w_next_busy;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_mask  = r_mask;
    w_next_count = r_count;
    w_next_load  = r_load;
    w_next_rn    = r_rn;
    w_next_ctrl  = r_ctrl;

    if (bus.flush) begin
      w_next_state = S_IDLE;
      w_next_mask  = '0;
      w_next_count = '0;
      w_next_ctrl  = '0;
    end else if (!bus.stall) begin
      case (r_state)
        S_IDLE: begin
          w_next_ctrl  = '0;
          w_next_mask  = '0;
          w_next_count = '0;
          if (bus.valid_in) begin
            if (bus.mode == MODE_BLOCK) begin
              if (w_found) begin
                w_next_ctrl  = block_op(bus.s, w_idx, '0);
                w_next_mask  = w_mask_rest;
                w_next_count = COUNT_LEN'(1);
                w_next_load  = bus.s;
                w_next_rn    = bus.rn;
                if (w_mask_rest != '0) w_next_state = S_SEQ;
`ifdef CU_BASE_WRITEBACK_EN
                else w_next_state = S_WB;
`endif
              end
            end else begin
              w_next_ctrl = decode_single(bus.mode, bus.opcode, bus.s, bus.immediate_in);
            end
          end
        end
        S_SEQ: begin
          w_next_ctrl  = block_op(r_load, w_idx, w_offset);
          w_next_mask  = w_mask_rest;
          w_next_count = r_count + COUNT_LEN'(1);
          if (w_mask_rest == '0) begin
`ifdef CU_BASE_WRITEBACK_EN
            w_next_state = S_WB;
`else
            w_next_state = S_IDLE;
`endif
          end
        end
`ifdef CU_BASE_WRITEBACK_EN
        S_WB: begin
          w_next_ctrl  = wb_op(r_rn, w_offset);
          w_next_mask  = '0;
          w_next_state = S_IDLE;
        end
`endif
        default: begin
          w_next_state = S_IDLE;
          w_next_mask  = '0;
          w_next_ctrl  = '0;
        end
      endcase
    end

    w_next_busy = (w_next_state != S_IDLE);
  end

  assign bus.valid_out           = r_ctrl.valid;
  assign bus.execute_command     = r_ctrl.exe_cmd;
  assign bus.mem_read            = r_ctrl.mem_read;
  assign bus.mem_write           = r_ctrl.mem_write;
  assign bus.wb_enable           = r_ctrl.wb_enable;
  assign bus.immediate           = r_ctrl.immediate;
  assign bus.branch_taken        = r_ctrl.branch_taken;
  assign bus.status_write_enable = r_ctrl.status_write_enable;
  assign bus.ignore_hazard       = r_ctrl.ignore_hazard;
  assign bus.dest_reg            = r_ctrl.dest_reg;
  assign bus.addr_offset         = r_ctrl.addr_offset;
  assign bus.busy                = r_busy;

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit: decode table, block/stall/flush sequences, random vs. queue model.
module tb_seq_control_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_control_unit_if bus();

  seq_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       valid;
    logic [3:0] cmd;
    logic       mr;
    logic       mw;
    logic       wb;
    logic       imm;
    logic       bt;
    logic       swe;
    logic       ih;
    logic [3:0] dest;
    logic [6:0] off;
    logic       busy;
  } out_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] op;
    logic       s;
    logic       imm;
    logic       e_valid;
    logic [3:0] e_cmd;
    logic       e_mr, e_mw, e_wb, e_imm, e_bt, e_swe, e_ih;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t cur     = '0;
  out_t q[$];

  // Model: each accepted instruction expands into its full list of micro-ops up front.
  function automatic logic [6:0] arith_ref(input logic [3:0] op);
    // {defined, cmd, wb, ignore_hazard}
    case (op)
      4'b0000: return {1'b1, 4'b0110, 1'b1, 1'b0};
      4'b0001: return {1'b1, 4'b1000, 1'b1, 1'b0};
      4'b0010: return {1'b1, 4'b0100, 1'b1, 1'b0};
      4'b0100: return {1'b1, 4'b0010, 1'b1, 1'b0};
      4'b0101: return {1'b1, 4'b0011, 1'b1, 1'b0};
      4'b0110: return {1'b1, 4'b0101, 1'b1, 1'b0};
      4'b1100: return {1'b1, 4'b0111, 1'b1, 1'b0};
      4'b1101: return {1'b1, 4'b0001, 1'b1, 1'b1};
      4'b1111: return {1'b1, 4'b1001, 1'b1, 1'b1};
      4'b1010: return {1'b1, 4'b0100, 1'b0, 1'b0};
      4'b1000: return {1'b1, 4'b0110, 1'b0, 1'b0};
      default: return 7'd0;
    endcase
  endfunction

  task automatic build_ops();
    out_t o;
    logic def;
    int   k;
    o = '0;
    o.valid = 1'b1;
    case (bus.mode)
      2'b00: begin
        {def, o.cmd, o.wb, o.ih} = arith_ref(bus.opcode);
        o.imm = bus.immediate_in;
        o.swe = def & bus.s;
        q.push_back(o);
      end
      2'b01: begin
        o.cmd = 4'b0010; o.imm = bus.immediate_in;
        o.mr = bus.s; o.wb = bus.s; o.mw = !bus.s;
        q.push_back(o);
      end
      2'b10: begin
        o.bt = 1'b1; o.ih = 1'b1;
        q.push_back(o);
      end
      default: begin
        k = 0;
        for (int i = 0; i < 16; i++) begin
          if (bus.reg_list[i]) begin
            o = '0; o.valid = 1'b1; o.cmd = 4'b0010; o.imm = 1'b1;
            o.mr = bus.s; o.wb = bus.s; o.mw = !bus.s;
            o.dest = 4'(i); o.off = 7'(4 * k);
            q.push_back(o);
            k++;
          end
        end
`ifdef CU_BASE_WRITEBACK_EN
        if (k > 0) begin
          o = '0; o.valid = 1'b1; o.cmd = 4'b0010; o.imm = 1'b1; o.wb = 1'b1;
          o.dest = bus.rn; o.off = 7'(4 * k);
          q.push_back(o);
        end
`endif
      end
    endcase
  endtask

  task automatic model_edge();
    if (!rst || bus.flush) begin
      q.delete();
      cur = '0;
    end else if (!bus.stall) begin
      if (q.size() == 0 && bus.valid_in) build_ops();
      if (q.size() == 0) begin
        cur = '0;
      end else begin
        cur      = q.pop_front();
        cur.busy = (q.size() != 0);
      end
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.valid = bus.valid_out;  o.cmd = bus.execute_command;
    o.mr    = bus.mem_read;   o.mw  = bus.mem_write;
    o.wb    = bus.wb_enable;  o.imm = bus.immediate;
    o.bt    = bus.branch_taken; o.swe = bus.status_write_enable;
    o.ih    = bus.ignore_hazard; o.dest = bus.dest_reg;
    o.off   = bus.addr_offset; o.busy = bus.busy;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One clock: model steps on the edge, DUT compared 1 time unit later.
  task automatic cycle(input string nm);
    out_t g;
    @(posedge clk);
    model_edge();
    #1;
    g = dut_out();
    n_tests++;
    if (g !== cur) begin
      n_fail++;
      $display("FAIL model_%s: got %h expected %h", nm, g, cur);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [1:0] m,
                       input logic [3:0] op, input logic s_i, input logic im,
                       input logic [3:0] rn_i, input logic [15:0] rl);
    bus.valid_in = v;   bus.stall = st;  bus.flush = fl;
    bus.mode     = m;   bus.opcode = op; bus.s = s_i;
    bus.immediate_in = im; bus.rn = rn_i; bus.reg_list = rl;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 20; i++) cycle("drain");
  endtask

  // {valid, dest, off, mem_read, mem_write, wb, busy}
  function automatic logic [31:0] seqv(input out_t o);
    return 32'({o.valid, o.dest, o.off, o.mr, o.mw, o.wb, o.busy});
  endfunction
  function automatic logic [31:0] mkseq(input logic v, input logic [3:0] d, input logic [6:0] of,
                                        input logic mr, input logic mw, input logic wb, input logic b);
    return 32'({v, d, of, mr, mw, wb, b});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t vt[16];
  logic b_wb;

  initial begin
`ifdef CU_BASE_WRITEBACK_EN
    b_wb = 1'b1;
`else
    b_wb = 1'b0;
`endif
    //       mode   op       s     imm   v     cmd      mr    mw    wb    imm   bt    swe   ih
    vt[0]  = {2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = {2'b00, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = {2'b00, 4'b0010, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = {2'b00, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = {2'b00, 4'b0101, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = {2'b00, 4'b0110, 1'b1, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = {2'b00, 4'b1100, 1'b0, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = {2'b00, 4'b1101, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = {2'b00, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[9]  = {2'b00, 4'b1010, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[10] = {2'b00, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = {2'b00, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = {2'b00, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = {2'b01, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[14] = {2'b01, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = {2'b10, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held two cycles with a valid ADD presented.
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      cycle("reset");
      chk("reset_all_zero", 32'(dut_out()), 32'd0);
    end
    rst = 1'b1;

    // Decode table, one instruction per cycle, latency 1.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, vt[i].mode, vt[i].op, vt[i].s, vt[i].imm, 4'h0, 16'h0);
      cycle("table");
      chk($sformatf("table_%0d", i),
          32'({bus.valid_out, bus.execute_command, bus.mem_read, bus.mem_write, bus.wb_enable,
               bus.immediate, bus.branch_taken, bus.status_write_enable, bus.ignore_hazard, bus.busy}),
          32'({vt[i].e_valid, vt[i].e_cmd, vt[i].e_mr, vt[i].e_mw, vt[i].e_wb,
               vt[i].e_imm, vt[i].e_bt, vt[i].e_swe, vt[i].e_ih, 1'b0}));
    end
    drain();

    // Block load 0x0025, rn=3; valid_in left high in SEQ must be ignored.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, 1'b1, 1'b0, 4'd3, 16'h0025);
    cycle("ldm0");
    chk("ldm_op0", seqv(dut_out()), mkseq(1'b1, 4'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    cycle("ldm1");
    chk("ldm_op1", seqv(dut_out()), mkseq(1'b1, 4'd2, 7'd4, 1'b1, 1'b0, 1'b1, 1'b1));
    bus.valid_in = 1'b0;
    cycle("ldm2");
    chk("ldm_op2", seqv(dut_out()), mkseq(1'b1, 4'd5, 7'd8, 1'b1, 1'b0, 1'b1, b_wb));
`ifdef CU_BASE_WRITEBACK_EN
    cycle("ldm_wb");
    chk("ldm_wb", seqv(dut_out()), mkseq(1'b1, 4'd3, 7'd12, 1'b0, 1'b0, 1'b1, 1'b0));
`endif
    cycle("ldm_end");
    chk("ldm_end", seqv(dut_out()), 32'd0);
    drain();

    // Store 0x00F0 stalled mid-sequence, then flushed.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 4'd1, 16'h00F0);
    cycle("stm0");
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      cycle("stall");
      chk("stall_frozen", seqv(dut_out()), mkseq(1'b1, 4'd4, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    end
    drive(1'b0, 1'b0, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
    cycle("flush");
    chk("flush_kill", seqv(dut_out()), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 4'h0, 16'h0);
    cycle("after_flush");
    chk("after_flush_accept", 32'({bus.valid_out, bus.execute_command, bus.busy}), 32'({1'b1, 4'b0010, 1'b0}));
    drain();

    // Empty list is a bubble; single bit 15 is a one-op transfer.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, 1'b1, 1'b0, 4'd7, 16'h0000);
    cycle("empty");
    chk("empty_list", seqv(dut_out()), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 4'd7, 16'h8000);
    cycle("bit15");
    chk("bit15_op", seqv(dut_out()), mkseq(1'b1, 4'd15, 7'd0, 1'b0, 1'b1, 1'b0, b_wb));
    drain();

    // flush and stall together mid-sequence: flush wins.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4'h0, 1'b1, 1'b0, 4'd2, 16'h0F0F);
    cycle("prio0");
    cycle("prio1");
    drive(1'b0, 1'b1, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
    cycle("prio");
    chk("flush_over_stall", seqv(dut_out()), 32'd0);
    drain();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] rl;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rl = 16'h0;
      else if (sel < 4)  rl = 16'(1) << $urandom_range(0, 15);
      else               rl = 16'($urandom) & 16'($urandom);
      rst = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), rl);
      cycle("random");
    end
    rst = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
